// File: rtl/capture_buffer_if.sv
// rtl/capture_buffer_if.sv - Wishbone target and sample-stream signal bundle for capture_buffer
interface capture_buffer_if;
  // Wishbone classic target
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [21:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        wb_rty_o;

  // Incoming 128-bit sample beats
  logic [127:0] buf_tdata;
  logic         buf_tvalid;
  logic         buf_tready;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o,
    input  buf_tdata, buf_tvalid,
    output buf_tready
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o,
    output buf_tdata, buf_tvalid,
    input  buf_tready
  );
endinterface

// File: rtl/capture_buffer.sv
// rtl/capture_buffer.sv - Triggered sample capture RAM with a Wishbone register/readback port
module capture_buffer #(
  parameter int unsigned DEPTH = 1024,
  parameter logic [31:0] ID    = "CAP0"
) (
  input logic             wb_clk_i,
  input logic             wb_rst_i,
  capture_buffer_if.slave bus
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [12:0] DEPTH_L = 13'(DEPTH);

  localparam logic [1:0] REG_ID     = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_LENGTH = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t       state;
  logic [12:0]  count;
  logic [12:0]  length;
  logic         rdy_q;

  logic [127:0] mem [DEPTH];
  logic [127:0] mem_rdata;

  // Wishbone transaction tracking: the request is latched on the first edge
  // it is seen and completed (ack, register effect) on the following edge.
  logic         pend;
  logic         ack_q;
  logic         q_is_buf;
  logic [1:0]   q_word;
  logic         q_we;
  logic [31:0]  q_dat;
  logic [31:0]  dat_o_q;
  logic [31:0]  rd_word;

  logic         start;
  logic         finish;
  logic         reg_wr;
  logic         ctrl_wr;
  logic         len_wr;
  logic         cmd_arm;
  logic         cmd_abort;
  logic         cmd_trig;
  logic         cap_we;
  logic [12:0]  len_new;
  logic [31:0]  status_word;
  logic         unused_bits;

  assign start     = bus.wb_cyc_i && bus.wb_stb_i && !pend && !ack_q;
  assign finish    = pend && bus.wb_cyc_i;
  assign reg_wr    = finish && q_we && !q_is_buf;
  assign ctrl_wr   = reg_wr && (q_word == REG_CTRL);
  assign len_wr    = reg_wr && (q_word == REG_LENGTH);
  assign cmd_arm   = ctrl_wr && q_dat[0];
  assign cmd_abort = ctrl_wr && q_dat[1];
  assign cmd_trig  = ctrl_wr && q_dat[2];

  // A beat lands in RAM only while capturing; an abort or reset on the same
  // edge takes priority and the beat is dropped.
  assign cap_we = (state == ST_CAPTURE) && bus.buf_tvalid && !cmd_abort && !wb_rst_i;

  // Out-of-range lengths (zero or beyond the RAM) fall back to full depth.
  assign len_new = ((q_dat == 32'd0) || (q_dat > 32'(DEPTH))) ? DEPTH_L : q_dat[12:0];

  assign status_word = {3'b000, count, 14'd0, state};

  assign bus.wb_dat_o   = dat_o_q;
  assign bus.wb_ack_o   = ack_q && bus.wb_cyc_i;
  assign bus.wb_err_o   = 1'b0;
  assign bus.wb_rty_o   = 1'b0;
  assign bus.buf_tready = rdy_q;

  // Byte lanes are ignored and only some address bits decode.
  assign unused_bits = ^{bus.wb_sel_i, bus.wb_adr_i};

  // Read-data selection for the completing transaction.
  always_comb begin
    rd_word = '0;
    if (q_is_buf) begin
      case (q_word)
        2'd0:    rd_word = mem_rdata[31:0];
        2'd1:    rd_word = mem_rdata[63:32];
        2'd2:    rd_word = mem_rdata[95:64];
        default: rd_word = mem_rdata[127:96];
      endcase
    end else begin
      case (q_word)
        REG_ID:     rd_word = ID;
        REG_STATUS: rd_word = status_word;
        REG_LENGTH: rd_word = {19'd0, length};
        default:    rd_word = '0;
      endcase
    end
  end

  // Capture RAM: stream writes at the running count, Wishbone read launched at request time.
  always_ff @(posedge wb_clk_i) begin
    if (cap_we) begin
      mem[count[AW-1:0]] <= bus.buf_tdata;
    end
    if (start) begin
      mem_rdata <= mem[bus.wb_adr_i[AW+3:4]];
    end
  end

  // Wishbone handshake: latch request, ack two cycles after strobe, drop if cyc goes away.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      pend     <= 1'b0;
      ack_q    <= 1'b0;
      q_is_buf <= 1'b0;
      q_word   <= 2'd0;
      q_we     <= 1'b0;
      q_dat    <= '0;
      dat_o_q  <= '0;
    end else begin
      ack_q <= finish;
      if (start) begin
        pend     <= 1'b1;
        q_is_buf <= bus.wb_adr_i[21];
        q_word   <= bus.wb_adr_i[3:2];
        q_we     <= bus.wb_we_i;
        q_dat    <= bus.wb_dat_i;
      end else if (pend) begin
        pend <= 1'b0;
      end
      if (finish && !q_we) begin
        dat_o_q <= rd_word;
      end
    end
  end

  // Capture control FSM with beat counter, LENGTH register and sink-ready flag.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state  <= ST_IDLE;
      count  <= '0;
      length <= DEPTH_L;
      rdy_q  <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (cmd_abort) begin
        state <= ST_IDLE;
        count <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cmd_arm) begin
              state <= ST_ARMED;
              count <= '0;
            end
          end
          ST_ARMED: begin
            if (cmd_trig) begin
              state <= ST_CAPTURE;
            end
          end
          ST_CAPTURE: begin
            if (bus.buf_tvalid) begin
              count <= count + 13'd1;
              if (count + 13'd1 == length) begin
                state <= ST_DONE;
              end
            end
          end
          ST_DONE: begin
            if (cmd_arm) begin
              state <= ST_ARMED;
              count <= '0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
      if (len_wr && ((state == ST_IDLE) || (state == ST_DONE))) begin
        length <= len_new;
      end
    end
  end

endmodule

// File: tb/tb_capture_buffer.sv
// tb/tb_capture_buffer.sv - Directed self-checking bench for capture_buffer
module tb_capture_buffer;

  localparam int DEPTH = 1024;
  localparam logic [21:0] A_ID     = 22'h000000;
  localparam logic [21:0] A_CTRL   = 22'h000004;
  localparam logic [21:0] A_STATUS = 22'h000008;
  localparam logic [21:0] A_LENGTH = 22'h00000C;
  localparam logic [21:0] A_BUF    = 22'h200000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  capture_buffer_if bus();

  capture_buffer #(.DEPTH(DEPTH)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Behavioural model: capture state as plain numbers, RAM as an array.
  int           m_state;
  logic [12:0]  m_count;
  logic [12:0]  m_len;
  logic         m_tready;
  int           m_xfer;
  logic         m_ack;
  logic         m_rd_chk;
  logic [31:0]  m_rd;
  logic [127:0] m_mem [DEPTH];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] beat(input int b);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[16*i+4 +: 12] = 12'(b*8 + i);
    return v;
  endfunction

  function automatic logic [31:0] model_read(input logic [21:0] a);
    logic [127:0] w;
    int k;
    if (a[21]) begin
      k = int'(a[13:2]);
      w = m_mem[k/4];
      return w[32*(k%4) +: 32];
    end
    case (a[3:2])
      2'd0:    return 32'h4341_5030;
      2'd2:    return {3'b000, m_count, 14'd0, 2'(m_state)};
      2'd3:    return {19'd0, m_len};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_write(input logic [21:0] a, input logic [31:0] d);
    if (a[21]) return;
    if (a[3:2] == 2'd1) begin
      if (d[1]) begin
        m_state = 0;
        m_count = 0;
      end else if (d[0] && (m_state == 0 || m_state == 3)) begin
        m_state = 1;
        m_count = 0;
      end else if (d[2] && m_state == 1) begin
        m_state = 2;
      end
    end else if (a[3:2] == 2'd3 && (m_state == 0 || m_state == 3)) begin
      m_len = (d == 0 || d > DEPTH) ? 13'(DEPTH) : d[12:0];
    end
  endtask

  // Applies one clock edge worth of rules: the read value reflects the state
  // before this edge, beats are taken next, and a write lands last.
  task automatic model_edge();
    logic ack_edge;
    logic is_wr;
    logic abort_now;
    if (rst) begin
      m_state = 0; m_count = 0; m_len = 13'(DEPTH);
      m_tready = 0; m_xfer = 0; m_ack = 0; m_rd_chk = 0;
      return;
    end
    m_tready = 1;
    if (bus.wb_cyc_i && bus.wb_stb_i) m_xfer++; else m_xfer = 0;
    ack_edge = (m_xfer == 2);
    m_ack    = ack_edge;
    m_rd_chk = ack_edge && !bus.wb_we_i;
    if (m_rd_chk) m_rd = model_read(bus.wb_adr_i);
    is_wr     = ack_edge && bus.wb_we_i;
    abort_now = is_wr && !bus.wb_adr_i[21] && bus.wb_adr_i[3:2] == 2'd1 && bus.wb_dat_i[1];
    if (m_state == 2 && bus.buf_tvalid && !abort_now) begin
      m_mem[m_count] = bus.buf_tdata;
      m_count = m_count + 13'd1;
      if (m_count == m_len) m_state = 3;
    end
    if (is_wr) model_write(bus.wb_adr_i, bus.wb_dat_i);
  endtask

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("tready", 32'(bus.buf_tready), 32'(m_tready));
      chk("ack", 32'(bus.wb_ack_o), 32'(m_ack));
      chk("err_rty", {30'd0, bus.wb_err_o, bus.wb_rty_o}, 32'd0);
      if (m_rd_chk) chk("rdata", bus.wb_dat_o, m_rd);
    end
  end

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic wb_xfer(input logic we, input logic [21:0] a, input logic [31:0] d,
                         input logic junk, output logic [31:0] rd);
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
    bus.wb_adr_i = a;    bus.wb_dat_i = d;
    if (junk) begin
      bus.buf_tvalid = 1'b1;
      bus.buf_tdata  = {4{32'hDEAD_BEEF}};
    end
    step();
    chk("ack_t1", 32'(bus.wb_ack_o), 32'd0);
    step();
    chk("ack_t2", 32'(bus.wb_ack_o), 32'd1);
    rd = bus.wb_dat_o;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.buf_tvalid = 1'b0;
    step();
  endtask

  task automatic wb_write(input logic [21:0] a, input logic [31:0] d);
    logic [31:0] rd;
    wb_xfer(1'b1, a, d, 1'b0, rd);
  endtask

  task automatic wb_read(input logic [21:0] a, output logic [31:0] rd);
    wb_xfer(1'b0, a, 32'd0, 1'b0, rd);
  endtask

  task automatic trigger(input logic junk);
    logic [31:0] rd;
    wb_xfer(1'b1, A_CTRL, 32'd4, junk, rd);
  endtask

  task automatic stream(input int first, input int n);
    for (int b = 0; b < n; b++) begin
      bus.buf_tvalid = 1'b1;
      bus.buf_tdata  = beat(first + b);
      step();
    end
    bus.buf_tvalid = 1'b0;
    bus.buf_tdata  = '0;
  endtask

  function automatic logic [21:0] bufw(input int k);
    return A_BUF | 22'(k << 2);
  endfunction

  initial begin
    logic [31:0] rd;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0;
    bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = 4'hF;
    bus.buf_tvalid = 0; bus.buf_tdata = '0;

    // Reset values
    step();
    chk_en = 1'b1;
    step();
    chk("rst_tready", 32'(bus.buf_tready), 32'd0);
    chk("rst_ack", 32'(bus.wb_ack_o), 32'd0);
    chk("rst_dat_o", bus.wb_dat_o, 32'd0);
    rst = 1'b0;
    step();
    chk("tready_up", 32'(bus.buf_tready), 32'd1);

    // ID, LENGTH and STATUS after reset
    wb_read(A_ID, rd);      chk("id", rd, 32'h4341_5030);
    wb_read(A_LENGTH, rd);  chk("len_rst", rd, 32'd1024);
    wb_read(A_STATUS, rd);  chk("status_rst", rd, 32'd0);
    wb_read(A_CTRL, rd);    chk("ctrl_rd", rd, 32'd0);

    // LENGTH=8 with tvalid alternating; invalid cycles carry junk
    wb_write(A_LENGTH, 32'd8);
    wb_write(A_CTRL, 32'd1);
    trigger(1'b0);
    for (int c = 0; c < 16; c++) begin
      bus.buf_tvalid = (c % 2 == 0);
      bus.buf_tdata  = (c % 2 == 0) ? beat(100 + c/2) : {4{32'hBAD0_BAD0}};
      step();
    end
    bus.buf_tvalid = 1'b0;
    wb_read(A_STATUS, rd);  chk("status_toggle", rd, 32'h0008_0003);
    wb_read(bufw(12), rd);  chk("toggle_w12", rd, 32'h3390_3380);
    for (int k = 0; k < 32; k++) wb_read(bufw(k), rd);

    // LENGTH=4 capture; junk beats during the trigger write, beat 4 overflow
    wb_write(A_LENGTH, 32'd4);
    wb_write(A_CTRL, 32'd1);
    wb_read(A_STATUS, rd);  chk("status_armed", rd, 32'h0000_0001);
    trigger(1'b1);
    stream(0, 5);
    wb_read(A_STATUS, rd);  chk("status_len4", rd, 32'h0004_0003);
    wb_read(bufw(0), rd);   chk("len4_w0", rd, 32'h0010_0000);
    wb_read(bufw(5), rd);   chk("len4_w5", rd, 32'h00B0_00A0);
    wb_read(bufw(15), rd);  chk("len4_w15", rd, 32'h01F0_01E0);
    wb_read(bufw(16), rd);  chk("beat4_kept", rd, 32'h3410_3400);
    for (int k = 0; k < 20; k++) wb_read(bufw(k), rd);

    // LENGTH clamping and write-protect during capture
    wb_write(A_LENGTH, 32'd0);
    wb_read(A_LENGTH, rd);  chk("len_zero", rd, 32'd1024);
    wb_write(A_LENGTH, 32'(DEPTH + 5));
    wb_read(A_LENGTH, rd);  chk("len_big", rd, 32'd1024);
    wb_write(A_LENGTH, 32'd8);
    wb_write(A_CTRL, 32'd1);
    trigger(1'b0);
    wb_read(A_STATUS, rd);  chk("status_cap", rd, 32'h0000_0002);
    wb_write(A_LENGTH, 32'd2);
    wb_write(A_CTRL, 32'd1);
    wb_read(A_LENGTH, rd);  chk("len_locked", rd, 32'd8);
    wb_write(A_CTRL, 32'd2);

    // Abort at 3 of 8, then recapture from address 0
    wb_write(A_CTRL, 32'd1);
    trigger(1'b0);
    stream(200, 3);
    wb_read(A_STATUS, rd);  chk("status_3of8", rd, 32'h0003_0002);
    wb_write(A_CTRL, 32'd2);
    wb_read(A_STATUS, rd);  chk("status_abort", rd, 32'd0);
    wb_write(A_CTRL, 32'd1);
    trigger(1'b0);
    stream(300, 8);
    wb_read(A_STATUS, rd);  chk("status_recap", rd, 32'h0008_0003);
    wb_read(bufw(0), rd);   chk("recap_w0", rd, 32'h9610_9600);
    for (int k = 0; k < 36; k++) wb_read(bufw(k), rd);

    // ARM|ABORT from DONE, then reset mid-capture
    wb_write(A_CTRL, 32'd3);
    wb_read(A_STATUS, rd);  chk("status_armabort", rd, 32'd0);
    wb_write(A_CTRL, 32'd1);
    trigger(1'b0);
    stream(400, 2);
    bus.buf_tvalid = 1'b1;
    bus.buf_tdata  = beat(402);
    rst = 1'b1;
    step();
    chk("midrst_tready", 32'(bus.buf_tready), 32'd0);
    step();
    rst = 1'b0;
    bus.buf_tvalid = 1'b0;
    step();
    chk("postrst_tready", 32'(bus.buf_tready), 32'd1);
    wb_read(A_STATUS, rd);  chk("status_postrst", rd, 32'd0);
    wb_read(A_LENGTH, rd);  chk("len_postrst", rd, 32'd1024);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
